// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seven_seg_scanner_if : display-side bus of the seven-segment scanner|
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface seven_seg_scanner_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        scan_tick;

  modport master (
    output enable, value, dp_en,
    input  an, seg, dp, digit_sel, scan_tick
  );

  modport slave (
    input  enable, value, dp_en,
    output an, seg, dp, digit_sel, scan_tick
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seven_seg_scanner : 4-digit common-anode hex scanner               |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module seven_seg_scanner #(
  parameter int SYNC_STAGES        = 2,
  parameter bit LEADING_ZERO_BLANK = 1'b1
) (
  input wire logic          clock,
  input wire logic          reset,
  input wire logic          div_clock,
  seven_seg_scanner_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   prev_ff;
  logic                   tick_ff;
  logic [1:0]             sel_ff;
  logic [3:0]             an_ff;
  logic [6:0]             seg_ff;
  logic                   dp_ff;

  logic [3:0] nib_nz;
  logic [3:0] cur_nib;
  logic       lz_blank;
  logic       blank;
  logic [6:0] seg_dec;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff <= '0;
      prev_ff <= 1'b0;
      tick_ff <= 1'b0;
      sel_ff  <= 2'd0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], div_clock};
      prev_ff <= sync_ff[SYNC_STAGES-1];
      tick_ff <= sync_ff[SYNC_STAGES-1] & ~prev_ff;
      if (tick_ff) begin
        sel_ff <= sel_ff + 2'd1;
      end
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_nib_nz
      assign nib_nz[i] = |bus.value[4*i +: 4];
    end
  endgenerate

  always_comb begin
    cur_nib  = bus.value[{sel_ff, 2'b00} +: 4];
    lz_blank = 1'b0;
    // Digit 0 is never zero-blanked, so a value of 0 still shows "0".
    case (sel_ff)
      2'd1:    lz_blank = ~|nib_nz[3:1];
      2'd2:    lz_blank = ~|nib_nz[3:2];
      2'd3:    lz_blank = ~nib_nz[3];
      default: lz_blank = 1'b0;
    endcase
    blank = ~bus.enable | (LEADING_ZERO_BLANK & lz_blank);
  end

  always_comb begin
    seg_dec = 7'b1111111;
    case (cur_nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || blank) begin
      an_ff  <= 4'b1111;
      seg_ff <= 7'b1111111;
      dp_ff  <= 1'b1;
    end else begin
      an_ff  <= ~(4'b0001 << sel_ff);
      seg_ff <= seg_dec;
      dp_ff  <= ~bus.dp_en[sel_ff];
    end
  end

  assign bus.an        = an_ff;
  assign bus.seg       = seg_ff;
  assign bus.dp        = dp_ff;
  assign bus.digit_sel = sel_ff;
  assign bus.scan_tick = tick_ff;

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Drives a 4-digit, common-anode seven-segment display from a 16-bit hex value, one digit at a time.
- Consumes the slow divided clock from the clock divider as a data input, not as a clock.
- Synchronizes that divided clock into the system clock domain and edge-detects it to form a scan-advance tick.
- All logic runs on the single 100 MHz system clock.

Parameters:
- SYNC_STAGES, 2: flip-flops in the div_clock synchronizer. Minimum 2.
- LEADING_ZERO_BLANK, 1: 1 blanks leading zero digits; 0 always shows all four digits.

Ports:
- clock  input  1  system clock, 100 MHz; every flop is clocked by it
- reset  input  1  synchronous, active-high reset
- div_clock  input  1  divided clock from the clock divider; treated as asynchronous data
- enable  input  1  1 lights the display; 0 blanks it
- value  input  16  hex value to show; nibble i drives digit i (digit 0 is the rightmost)
- dp_en  input  4  decimal-point enable per digit
- an  output  4  anode selects, active-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- digit_sel  output  2  index of the digit currently being scanned
- scan_tick  output  1  single-cycle pulse when the scan advances

Behaviour:
- Reset: "Already decided": one clock (clock); reset is synchronous and active-high (reset). Reset is sampled only on a rising edge of clock. While reset is high at an edge, the following are set:
  - synchronizer flops = 0 and the edge-history flop = 0
  - digit_sel = 0, scan_tick = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1
- Synchronizer: div_clock passes through SYNC_STAGES flops (sN is the last stage); prev is a register of sN.
  - scan_tick = sN & ~prev, registered, so it is exactly one clock wide.
  - With SYNC_STAGES=2, a div_clock rising edge sampled at clock edge k gives scan_tick high in the cycle after edge k+2.
  - Falling edges of div_clock produce no tick.
- Digit counter: on an edge where scan_tick=1, digit_sel <= digit_sel+1. It wraps 3 -> 0. It holds otherwise.
  - It advances regardless of enable.
  - Reset has priority over the tick.
- Output stage: an, seg and dp are registered every cycle from the current digit_sel, value, dp_en, enable and blank state. This gives 1-cycle latency from any input change to the outputs.
- Lit slot: an = one-hot-low at digit_sel (0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111).
  - seg = decode(value[4*digit_sel +: 4]).
  - dp = ~dp_en[digit_sel].
- Blanked slot: an = 1111, seg = 1111111, dp = 1. A slot is blanked if either condition holds:
  - enable = 0, or
  - LEADING_ZERO_BLANK = 1, digit_sel > 0, and every nibble from digit_sel up to digit 3 is zero.
- Digit 0 is never blanked by zero-blanking, so a value of 0 shows a single "0".
- Decode table, {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Boundary cases:
  - div_clock held high through reset release: counts as one rising edge, giving one tick SYNC_STAGES cycles after release.
  - Reset mid-scan: digit_sel returns to 0 at the next edge and the outputs go dark for that cycle.
  - value changes mid-slot: the new value appears on the next clock edge; the scan is not restarted.
  - div_clock pulse shorter than one clock period: may be missed. div_clock half-period must be at least 2 clock periods.

Test Plan:
- Reset: hold reset 3 cycles with div_clock toggling -> an=1111, seg=1111111, dp=1, digit_sel=0, scan_tick=0 throughout.
- Scan with value=16'h1234, dp_en=0, enable=1, div_clock period 8 clocks:
  - first, a tick SYNC_STAGES+1 cycles after each div_clock rise;
  - then the outputs step an/seg 1110/0011001 -> 1101/0110000 -> 1011/0100100 -> 0111/1111001 -> wrap to digit 0.
- Blanking: value=16'h0005 with LEADING_ZERO_BLANK=1 -> only digit 0 lights (seg=0010010); slots 1-3 give an=1111. value=0 -> digit 0 shows 1000000. With LEADING_ZERO_BLANK=0, all four digits light.
- dp and enable: dp_en=4'b0100 -> dp=0 only when digit_sel=2. Drop enable to 0 -> an=1111 one cycle later while digit_sel keeps counting; restore enable -> the display resumes at the current digit.
- Reset mid-scan at digit_sel=2 -> digit_sel=0 and an=1111 on the edge after reset. After release with div_clock high, exactly one tick fires SYNC_STAGES cycles later.
- Hex coverage: sweep value nibble 0..F on digit 0 -> seg matches the decode table for each of the 16 codes, with a 1-cycle lag.
